// File: rtl/dvp_cam_pwr_clk_ctrl_if.sv
// DCR-to-camera control bundle: configuration word in, sensor pins and status out.
interface dvp_cam_pwr_clk_ctrl_if #(
    parameter int CFG_W = 32
);
    logic [CFG_W-1:0] dcr_cam_cfg_i;
    logic             dvp_xclk_o;
    logic             dvp_pwdn_o;
    logic             dvp_rst_n_o;
    logic             cam_ready_o;
    logic [2:0]       cam_state_o;

    modport master (
        output dcr_cam_cfg_i,
        input  dvp_xclk_o, dvp_pwdn_o, dvp_rst_n_o, cam_ready_o, cam_state_o
    );

    modport slave (
        input  dcr_cam_cfg_i,
        output dvp_xclk_o, dvp_pwdn_o, dvp_rst_n_o, cam_ready_o, cam_state_o
    );
endinterface

// File: rtl/dvp_cam_pwr_clk_ctrl.sv
// DVP camera XCLK divider plus PWDN/reset power sequencer with ready/state readback.
// Optional DVP_XCLK_DIV_SHADOW_EN: divider captured only at XCLK fall or power-up entry.
module dvp_cam_pwr_clk_ctrl #(
    parameter int CFG_W         = 32,
    parameter int DIV_W         = 8,
    parameter int RST_HOLD_CYC  = 1024,
    parameter int PWUP_WAIT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dvp_cam_pwr_clk_ctrl_if.slave    cam_if
);
    localparam int SEQ_MAX = (RST_HOLD_CYC > PWUP_WAIT_CYC) ? RST_HOLD_CYC : PWUP_WAIT_CYC;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(RST_HOLD_CYC - 1);
    localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(PWUP_WAIT_CYC - 1);
    localparam logic [SEQ_W-1:0] SEQ_ONE   = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWUP    = 3'd1,
        ST_RST_REL = 3'd2,
        ST_READY   = 3'd3,
        ST_SHDN    = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SEQ_W-1:0] r_seq;
    logic [DIV_W-1:0] r_cnt, r_div_q, w_half, w_div;
    logic             r_xclk, r_pwdn, r_rst_n, r_ready;
    logic             w_pwdn_nxt, w_rst_n_nxt, w_ready_nxt;
    logic             w_en, w_active, w_run, w_tgl, w_chg;
    logic             w_unused_cfg;

    assign w_half       = cam_if.dcr_cam_cfg_i[8 +: DIV_W];
    assign w_en         = cam_if.dcr_cam_cfg_i[0] & ~cam_if.dcr_cam_cfg_i[1];
    assign w_unused_cfg = ^{cam_if.dcr_cam_cfg_i[CFG_W-1:8+DIV_W], cam_if.dcr_cam_cfg_i[7:2]};

    assign w_active = (r_state == ST_PWUP) | (r_state == ST_RST_REL) | (r_state == ST_READY);
    // In shutdown the clock only finishes a high phase; a low XCLK stays frozen.
    assign w_run    = w_active | ((r_state == ST_SHDN) & r_xclk);
    assign w_tgl    = w_run & ~w_chg & (r_cnt == (w_div - DIV_ONE));

`ifdef DVP_XCLK_DIV_SHADOW_EN
    assign w_div = (r_div_q == {DIV_W{1'b0}}) ? DIV_ONE : r_div_q;
    assign w_chg = 1'b0;

    // Shadow divider: load only where a new phase begins low, so no phase is cut or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q <= {DIV_W{1'b0}};
        end else if (((r_state == ST_OFF) && (w_state_nxt == ST_PWUP)) || (w_tgl && r_xclk)) begin
            r_div_q <= w_half;
        end else begin
            r_div_q <= r_div_q;
        end
    end
`else
    assign w_div = (w_half == {DIV_W{1'b0}}) ? DIV_ONE : w_half;
    assign w_chg = (w_half != r_div_q);

    // Remember the last divider field so a change restarts the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q <= {DIV_W{1'b0}};
        end else begin
            r_div_q <= w_half;
        end
    end
`endif

    // Half-period counter and XCLK toggle flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= {DIV_W{1'b0}};
            r_xclk <= 1'b0;
        end else begin
            r_cnt  <= (!w_run || w_tgl || w_chg) ? {DIV_W{1'b0}} : (r_cnt + DIV_ONE);
            r_xclk <= r_xclk ^ w_tgl;
        end
    end

    // State register and sequence counter, which restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_seq   <= {SEQ_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_seq <= {SEQ_W{1'b0}};
            end else if ((r_state == ST_PWUP) || (r_state == ST_RST_REL)) begin
                r_seq <= r_seq + SEQ_ONE;
            end else begin
                r_seq <= {SEQ_W{1'b0}};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:     w_state_nxt = w_en ? ST_PWUP : ST_OFF;
            ST_PWUP:    w_state_nxt = !w_en ? ST_SHDN : ((r_seq == HOLD_LAST) ? ST_RST_REL : ST_PWUP);
            ST_RST_REL: w_state_nxt = !w_en ? ST_SHDN : ((r_seq == WAIT_LAST) ? ST_READY : ST_RST_REL);
            ST_READY:   w_state_nxt = !w_en ? ST_SHDN : ST_READY;
            ST_SHDN:    w_state_nxt = r_xclk ? ST_SHDN : ST_OFF;
            default:    w_state_nxt = ST_OFF;
        endcase
    end

    // Pin levels decoded from the next state so they register in step with the state.
    always_comb begin
        w_pwdn_nxt  = 1'b1;
        w_rst_n_nxt = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            ST_PWUP, ST_SHDN: begin
                w_pwdn_nxt = 1'b0;
            end
            ST_RST_REL: begin
                w_pwdn_nxt  = 1'b0;
                w_rst_n_nxt = 1'b1;
            end
            ST_READY: begin
                w_pwdn_nxt  = 1'b0;
                w_rst_n_nxt = 1'b1;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_pwdn_nxt  = 1'b1;
                w_rst_n_nxt = 1'b0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Registered sensor pins and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwdn  <= 1'b1;
            r_rst_n <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_pwdn  <= w_pwdn_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign cam_if.dvp_xclk_o  = r_xclk;
    assign cam_if.dvp_pwdn_o  = r_pwdn;
    assign cam_if.dvp_rst_n_o = r_rst_n;
    assign cam_if.cam_ready_o = r_ready;
    assign cam_if.cam_state_o = r_state;
endmodule

// File: tb/tb_dvp_cam_pwr_clk_ctrl.sv
// Scoreboard bench: stimulus queues the expected pin/status vector per cycle, a monitor checks it.
module tb_dvp_cam_pwr_clk_ctrl;
    typedef struct {
        logic [6:0] v;
        int         id;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    sb_t  sb_q[$];
    sb_t  mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   g_id   = 0;

    always #5 clk = ~clk;

    dvp_cam_pwr_clk_ctrl_if #(.CFG_W(32)) cam_if ();

    dvp_cam_pwr_clk_ctrl #(
        .CFG_W(32), .DIV_W(8), .RST_HOLD_CYC(8), .PWUP_WAIT_CYC(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cam_if(cam_if)
    );

    // Vector layout: {state[2:0], pwdn, rst_n, ready, xclk}
    function automatic logic [6:0] act_vec();
        return {cam_if.cam_state_o, cam_if.dvp_pwdn_o, cam_if.dvp_rst_n_o,
                cam_if.cam_ready_o, cam_if.dvp_xclk_o};
    endfunction

    function automatic logic [2:0] st_of(input int n);
        if (n < 8) return 3'd1;
        else if (n < 24) return 3'd2;
        else return 3'd3;
    endfunction

    function automatic logic xc3(input int n);
        return ((n / 3) % 2) == 1;
    endfunction

    // XCLK after the half 3->5 change written at n=10 while XCLK is high.
    function automatic logic xc_chg(input int n);
        if (n < 10) return xc3(n);
`ifdef DVP_XCLK_DIV_SHADOW_EN
        if (n < 12) return 1'b1;
        return (((n - 12) / 5) % 2) == 1;
`else
        if (n < 15) return 1'b1;
        return (((n - 15) / 5) % 2) == 1;
`endif
    endfunction

    task automatic check(input string name, input int id, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got st=%0d pwdn=%b rstn=%b rdy=%b xclk=%b, want st=%0d pwdn=%b rstn=%b rdy=%b xclk=%b",
                     name, id, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic [31:0] cfg, input logic [2:0] st, input logic pw,
                        input logic rn, input logic rdy, input logic xc);
        sb_t e;
        @(negedge clk);
        cam_if.dcr_cam_cfg_i = cfg;
        e.v  = {st, pw, rn, rdy, xc};
        e.id = g_id;
        g_id++;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are presented every clock; compare just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("seq", mon_e.id, act_vec(), mon_e.v);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cam_if.dcr_cam_cfg_i = 32'h0000_0000;
        #23;
        check("reset_defaults", -1, act_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up with half=3: hold 8, wait 16, XCLK period 6.
        for (int k = 0; k < 34; k++) step(32'h0000_0301, st_of(k), 1'b0, k >= 8, k >= 24, xc3(k));
        // pwdn_req while XCLK high: finish high phase, then OFF.
        step(32'h0000_0303, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0303, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0303, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(32'h0000_0303, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // half=0 acts as 1: XCLK = clk/2.
        for (int j = 0; j < 12; j++) step(32'h0000_0001, st_of(j), 1'b0, j >= 8, 1'b0, (j % 2) == 1);
        step(32'h0000_0002, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(32'h0000_0002, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Drop start at PWUP cycle 4, re-assert during SHDN.
        for (int m = 0; m < 4; m++) step(32'h0000_0301, 3'd1, 1'b0, 1'b0, 1'b0, xc3(m));
        step(32'h0000_0300, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0301, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0301, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0301, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) step(32'h0000_0301, st_of(n), 1'b0, n >= 8, 1'b0, xc3(n));

        // Divider 3->5 while XCLK high, continuing into READY.
        for (int n = 10; n < 31; n++) step(32'h0000_0501, st_of(n), 1'b0, n >= 8, n >= 24, xc_chg(n));

        @(negedge clk);
        n_chk++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
        end

        // Asynchronous reset mid-operation goes straight to reset values.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", -2, act_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        check("reset_hold", -3, act_vec(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
